// File: rtl/word_array_mem.sv
// Clocked word array: DEPTH x WIDTH storage behind one request port, with a
// registered read, out-of-range error pulse and a hardware clear sequencer.
module word_array_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clr,
  output logic              busy,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic              err
);

  // state   | meaning
  // S_CLEAR | zeroing mem[clr_ptr] each clock, requests ignored, busy=1
  // S_IDLE  | serving req (read/write/err) and watching clr
  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  // Storage index only needs enough bits for DEPTH; addr may be wider.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              rd_en;
  logic              err_set;
  logic [IDX_W-1:0]  rd_idx;

  // Extra top bit keeps the unsigned compare valid when 2**ADDR_W == DEPTH.
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign rd_idx   = addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    busy         = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = clr_ptr[IDX_W-1:0];
    mem_wdata    = '0;
    rd_en        = 1'b0;
    err_set      = 1'b0;
    case (state)
      S_CLEAR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_next   = S_IDLE;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + 1'b1;
        end
      end
      S_IDLE: begin
        if (clr) begin
          // A same-cycle req is dropped in favour of the clear.
          state_next   = S_CLEAR;
          clr_ptr_next = '0;
        end else if (req) begin
          if (!in_range) begin
            err_set = 1'b1;
          end else if (op) begin
            mem_we    = 1'b1;
            mem_waddr = addr[IDX_W-1:0];
            mem_wdata = wr_data;
          end else begin
            rd_en = 1'b1;
          end
        end
      end
      default: begin
        state_next   = S_CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // Storage has no reset; the clear sequence defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      err      <= err_set;
      if (rd_en) begin
        rd_data <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_word_array_mem.sv
// Self-checking bench for word_array_mem: a 16x8 instance with ADDR_W=4 and a
// second 16x8 instance with ADDR_W=5 for out-of-range accesses.
module tb_word_array_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       req_a, op_a, clr_a;
  logic [3:0] addr_a;
  logic [7:0] wd_a;
  logic       busy_a, rv_a, err_a;
  logic [7:0] rd_a;

  logic       req_b, op_b, clr_b;
  logic [4:0] addr_b;
  logic [7:0] wd_b;
  logic       busy_b, rv_b, err_b;
  logic [7:0] rd_b;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model[16];

  word_array_mem #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .op(op_a), .addr(addr_a),
    .wr_data(wd_a), .clr(clr_a), .busy(busy_a), .rd_valid(rv_a),
    .rd_data(rd_a), .err(err_a)
  );

  word_array_mem #(.WIDTH(8), .DEPTH(16), .ADDR_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .op(op_b), .addr(addr_b),
    .wr_data(wd_b), .clr(clr_b), .busy(busy_b), .rd_valid(rv_b),
    .rd_data(rd_b), .err(err_b)
  );

  // One clock on dut_a: drive at negedge, compare at the following negedge.
  task automatic cyc_a(input logic r, input logic o, input logic [3:0] a,
                       input logic [7:0] d, input logic c);
    logic rd_exp;
    logic [7:0] exp;
    rd_exp = r && !o && !c && !busy_a;
    if (rd_exp) exp_q.push_back(model[a]);
    if (r && o && !c && !busy_a) model[a] = d;
    if (c && !busy_a) foreach (model[i]) model[i] = 8'h00;
    req_a = r; op_a = o; addr_a = a; wd_a = d; clr_a = c;
    @(negedge clk);
    req_a = 1'b0; clr_a = 1'b0;
    tests++;
    if (rv_a !== rd_exp) begin
      fails++;
      $display("FAIL a_rd_valid addr=%0d got=%b exp=%b", a, rv_a, rd_exp);
    end
    tests++;
    if (err_a !== 1'b0) begin
      fails++;
      $display("FAIL a_err addr=%0d got=%b exp=0", a, err_a);
    end
    if (rd_exp && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      tests++;
      if (rd_a !== exp) begin
        fails++;
        $display("FAIL a_rd_data addr=%0d got=%h exp=%h", a, rd_a, exp);
      end
    end
  endtask

  task automatic cyc_b(input logic r, input logic o, input logic [4:0] a,
                       input logic [7:0] d);
    req_b = r; op_b = o; addr_b = a; wd_b = d;
    @(negedge clk);
    req_b = 1'b0;
  endtask

  // Counts consecutive busy samples on dut_a, optionally poking requests.
  task automatic count_busy(input string name, input logic poke);
    int n;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      n++;
      cyc_a(poke && (n == 3 || n == 5), (n == 3), 4'd5, 8'hEE, 1'b0);
    end
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL %s busy_cycles got=%0d exp=16", name, n);
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) cyc_a(1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy_a !== 1'b1 || rv_a !== 1'b0 || rd_a !== 8'h00 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_state got busy=%b rv=%b rd=%h err=%b exp 1 0 00 0",
               busy_a, rv_a, rd_a, err_a);
    end
    rst_n = 1'b1;
    count_busy("reset_release", 1'b0);
    read_all_zero();
  endtask

  task automatic test_write_read();
    cyc_a(1'b1, 1'b1, 4'd3, 8'b01010101, 1'b0);
    cyc_a(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    cyc_a(1'b1, 1'b0, 4'd4, 8'h00, 1'b0);
    cyc_a(1'b1, 1'b1, 4'd0, 8'h81, 1'b0);
    cyc_a(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    cyc_a(1'b1, 1'b1, 4'd15, 8'hCC, 1'b0);
    cyc_a(1'b1, 1'b0, 4'd15, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b0, 1'b0, 4'd15, 8'h00, 1'b0);
      tests++;
      if (rd_a !== 8'hCC) begin
        fails++;
        $display("FAIL b2b_hold cycle=%0d got=%h exp=cc", i, rd_a);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp;
    cyc_b(1'b1, 1'b1, 5'd4, 8'h5A);
    exp_q.push_back(8'h5A);
    cyc_b(1'b1, 1'b0, 5'd4, 8'h00);
    exp = exp_q.pop_front();
    tests++;
    if (rv_b !== 1'b1 || rd_b !== exp || err_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_inrange_read got rv=%b rd=%h err=%b exp 1 %h 0", rv_b, rd_b, err_b, exp);
    end
    cyc_b(1'b1, 1'b0, 5'd20, 8'h00);
    tests++;
    if (err_b !== 1'b1 || rv_b !== 1'b0 || rd_b !== 8'h5A) begin
      fails++;
      $display("FAIL oor_read20 got err=%b rv=%b rd=%h exp 1 0 5a", err_b, rv_b, rd_b);
    end
    cyc_b(1'b0, 1'b0, 5'd0, 8'h00);
    tests++;
    if (err_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_err_pulse got=%b exp=0", err_b);
    end
    cyc_b(1'b1, 1'b1, 5'd20, 8'hFF);
    tests++;
    if (err_b !== 1'b1 || rv_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_write20 got err=%b rv=%b exp 1 0", err_b, rv_b);
    end
    exp_q.push_back(8'h5A);
    cyc_b(1'b1, 1'b0, 5'd4, 8'h00);
    exp = exp_q.pop_front();
    tests++;
    if (rv_b !== 1'b1 || rd_b !== exp || err_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_no_alias got rv=%b rd=%h err=%b exp 1 %h 0", rv_b, rd_b, err_b, exp);
    end
    cyc_b(1'b1, 1'b0, 5'd16, 8'h00);
    tests++;
    if (err_b !== 1'b1 || rv_b !== 1'b0) begin
      fails++;
      $display("FAIL oor_addr16 got err=%b rv=%b exp 1 0", err_b, rv_b);
    end
    exp_q.push_back(8'h00);
    cyc_b(1'b1, 1'b0, 5'd15, 8'h00);
    exp = exp_q.pop_front();
    tests++;
    if (err_b !== 1'b0 || rv_b !== 1'b1 || rd_b !== exp) begin
      fails++;
      $display("FAIL oor_addr15 got err=%b rv=%b rd=%h exp 0 1 %h", err_b, rv_b, rd_b, exp);
    end
  endtask

  task automatic test_clear();
    cyc_a(1'b1, 1'b1, 4'd5, 8'hAB, 1'b1);
    count_busy("clear_busy", 1'b1);
    read_all_zero();
  endtask

  task automatic test_reset_mid_clear();
    cyc_a(1'b1, 1'b1, 4'd7, 8'h3C, 1'b0);
    cyc_a(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (6) cyc_a(1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #2;
    tests++;
    if (busy_a !== 1'b1 || rv_a !== 1'b0 || err_a !== 1'b0) begin
      fails++;
      $display("FAIL mid_clear_reset got busy=%b rv=%b err=%b exp 1 0 0", busy_a, rv_a, err_a);
    end
    rst_n = 1'b1;
    count_busy("reset_mid_clear", 1'b0);
    foreach (model[i]) model[i] = 8'h00;
    read_all_zero();
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; op_a = 1'b0; clr_a = 1'b0; addr_a = '0; wd_a = '0;
    req_b = 1'b0; op_b = 1'b0; clr_b = 1'b0; addr_b = '0; wd_b = '0;
    foreach (model[i]) model[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
